// File: rtl/monolith_hash_arbiter.sv
// Round-robin arbiter that shares one monolith_hash engine among NUM_REQ requesters,
// holding the granted state at the engine and routing the result (or a timeout) back.
module monolith_hash_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PERM_SIZE = 16,
    parameter int WORD_W    = 31,
    parameter int TIMEOUT   = 256
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*PERM_SIZE*WORD_W-1:0]   req_state,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    input  logic [NUM_REQ-1:0]                    rsp_ready,
    output logic [PERM_SIZE*WORD_W-1:0]           rsp_state,
    output logic                                  rsp_err,
    output logic                                  hash_rst,
    output logic [PERM_SIZE*WORD_W-1:0]           hash_state_in,
    input  logic [PERM_SIZE*WORD_W-1:0]           hash_state_out,
    input  logic                                  hash_valid,
    output logic                                  busy,
    output logic [31:0]                           jobs_done,
    output logic                                  timeout_sticky
);

    localparam int ST_W  = PERM_SIZE * WORD_W;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gsel;
    logic [PTR_W-1:0]   grant;
    logic               grant_found;
    logic [PTR_W:0]     cand;
    logic [CNT_W-1:0]   cnt;

    // Rotating priority search starting at rr_ptr; one extra bit avoids overflow before the wrap.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_EXT) begin
                cand = cand - NUM_REQ_EXT;
            end
            if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is suppressed while reset is asserted so no handshake is lost to a reset edge.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        hash_rst   = 1'b1;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = aresetn;
                    state_next       = COMPUTE;
                end
            end
            COMPUTE: begin
                hash_rst = 1'b0;
                if (hash_valid || (cnt == CNT_LAST)) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid[gsel] = 1'b1;
                if (rsp_ready[gsel]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr         <= '0;
            gsel           <= '0;
            cnt            <= '0;
            hash_state_in  <= '0;
            rsp_state      <= '0;
            rsp_err        <= 1'b0;
            jobs_done      <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        hash_state_in <= req_state[grant*ST_W +: ST_W];
                        gsel          <= grant;
                        cnt           <= '0;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 1'b1;
                    // A result arriving on the last allowed cycle still counts as success.
                    if (hash_valid) begin
                        rsp_state <= hash_state_out;
                        rsp_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rsp_state      <= '0;
                        rsp_err        <= 1'b1;
                        timeout_sticky <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[gsel]) begin
                        rr_ptr <= (gsel == PTR_LAST) ? '0 : gsel + 1'b1;
                        if (!rsp_err) begin
                            jobs_done <= jobs_done + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
